// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with two-flop synchroniser, mid-bit sampling and a receive buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry circular buffer; otherwise a single holding register is used.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rxd_i,
  input  logic       rd_i,
  input  logic       clr_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       overrun_o,
  output logic       frame_err_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic            rxs_meta_q, rxs_q, rxs_dly_q;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            push, frame_set, overrun_set;
  logic            do_push, do_pop;
  logic            valid_q, valid_d;
  logic [7:0]      data_q, head_d;
  logic            overrun_q, overrun_d, frame_err_q, frame_err_d;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (rxs_dly_q && !rxs_q) state_d = START;
      end
      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rxs_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
          push      = rxs_q;
          frame_set = !rxs_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic        empty, full;

  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_pop      = rd_i && !empty;
  assign do_push     = push && (!full || do_pop);
  assign overrun_set = push && full && !do_pop;
  assign wr_ptr_d    = wr_ptr_q + (AW+1)'(do_push);
  assign rd_ptr_d    = rd_ptr_q + (AW+1)'(do_pop);
  assign valid_d     = (wr_ptr_d != rd_ptr_d);

  // The incoming byte bypasses the array when it lands in the slot that becomes the head.
  always_comb begin
    head_d = mem_q[rd_ptr_d[AW-1:0]];
    if (do_push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) head_d = shift_q;
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;

  assign do_pop      = rd_i && valid_q;
  assign do_push     = push && (!valid_q || do_pop);
  assign overrun_set = push && valid_q && !do_pop;
  assign valid_d     = do_push || (valid_q && !do_pop);
  assign head_d      = do_push ? shift_q : data_q;
`endif

  // Set has priority over clear on the sticky flags.
  assign overrun_d   = overrun_set || (overrun_q && !clr_i);
  assign frame_err_d = frame_set || (frame_err_q && !clr_i);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rxs_meta_q  <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_dly_q   <= 1'b1;
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rxs_meta_q  <= rxd_i;
      rxs_q       <= rxs_meta_q;
      rxs_dly_q   <= rxs_q;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      valid_q     <= valid_d;
      data_q      <= head_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign overrun_o   = overrun_q;
  assign frame_err_o = frame_err_q;
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the SoC's unused `RXD` pin: synchronises the asynchronous line, deframes 8N1 characters by mid-bit sampling, and buffers received bytes for the memory-mapped IO block. It sits directly upstream of the IO block, which polls `valid_o`, reads `data_o` and pops with `rd_i`, completing the UART alongside the existing transmitter on `TXD`.

## Interface
- `CLKS_PER_BIT`, 434: system clocks per bit (50 MHz / 115200); must be ≥ 4.
- `FIFO_DEPTH`, 4: receive buffer entries; power of two, ≥ 2. Used only with `UART_RX_FIFO_EN`.
- `clk_i` in 1: system clock, rising edge.
- `reset_i` in 1: asynchronous, active-low reset.
- `rxd_i` in 1: raw serial line, idle high, asynchronous to `clk_i`.
- `rd_i` in 1: pop strobe from IO, one byte per cycle asserted.
- `clr_i` in 1: clears the sticky error flags.
- `data_o` out 8: oldest unread byte; valid only while `valid_o` = 1.
- `valid_o` out 1: at least one unread byte.
- `overrun_o` out 1: sticky; a byte was dropped because the buffer was full.
- `frame_err_o` out 1: sticky; a stop bit was sampled low.

## Operation
- Synchroniser: two flops on `rxd_i`, both reset to 1. All logic uses the second flop (`rxs`) and its one-cycle-delayed copy.
- FSM states: IDLE, START, DATA, STOP. Bit counter is 3 bits. Clock counter is `$clog2(CLKS_PER_BIT)` bits and is cleared on every state transition.
- IDLE: on a falling edge of `rxs` (previous 1, current 0), go to START. A line held low does not retrigger.
- START: at count `CLKS_PER_BIT/2 - 1` (integer division), sample `rxs`. If 0, go to DATA. If 1, treat as a glitch and return to IDLE with no flag.
- DATA: at count `CLKS_PER_BIT - 1`, shift `rxs` into the shift register LSB-first. After the 8th bit, go to STOP.
- STOP: at count `CLKS_PER_BIT - 1`, sample `rxs`:
  - If 1, push the shift-register byte.
  - If 0, set `frame_err_o` and drop the byte.
  - Either way, return to IDLE.
- Buffer: circular, with read and write pointers of `$clog2(FIFO_DEPTH)+1` bits. Empty when the pointers are equal; full when the low bits are equal and the MSBs differ. Pointers wrap naturally.
- Push while full with no pop in the same cycle: drop the byte and set `overrun_o`.
- Push and pop in the same cycle while full: both happen and occupancy is unchanged.
- `rd_i` while empty: ignored, no pointer change.
- `clr_i`: clears both flags the next cycle. If a set event occurs in the same cycle, set wins.
- Reset (asynchronous, any time, including mid-character):
  - FSM goes to IDLE, counters to 0, buffer empties.
  - `data_o` = 0, `valid_o` = 0, `overrun_o` = 0, `frame_err_o` = 0.
  - Partially received bytes are discarded.

## Timing
- Let E be the first cycle with `rxs` = 0, which is 2 cycles after `rxd_i` falls.
- Stop bit is sampled at E + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`.
- Push is registered on that edge. `valid_o` and `data_o` are updated one cycle after the stop sample.
- `data_o` is the registered head entry.
- Pop: with `rd_i` high at edge N, `data_o` shows the next entry after N, or `valid_o` falls if the buffer becomes empty.
- Back-to-back characters with no idle gap are received; the next start-bit edge is detectable in the cycle after STOP completes.

## Configuration
- `UART_RX_FIFO_EN` defined: `FIFO_DEPTH`-entry circular buffer as described above.
- `UART_RX_FIFO_EN` undefined: single holding register; `FIFO_DEPTH` is ignored.
  - Full means `valid_o` = 1.
  - Overrun, same-cycle push/pop and empty-read rules are identical to the FIFO case with depth 1.

## Test plan
Unless noted, `CLKS_PER_BIT`=16 and `FIFO_DEPTH`=4 with `UART_RX_FIFO_EN` defined.
- Single frame: send 0xA5 (8N1) → `valid_o` rises at E+153; `data_o`=0xA5; after one `rd_i`, `valid_o`=0; flags stay 0.
- Glitch: drive `rxd_i` low for 5 cycles, then high → FSM returns to IDLE; no `valid_o`; no flags.
- Overrun: send 0x01–0x05 back-to-back with no reads → `data_o` pops 0x01, 0x02, 0x03, 0x04; `overrun_o`=1; `clr_i` clears it next cycle.
- Framing error: send 0x3C with the stop bit low → `frame_err_o`=1; `valid_o`=0; a following valid 0x7E is received correctly.
- Full with simultaneous pop: buffer full, `rd_i` asserted on the push cycle → no overrun; occupancy stays 4; order is preserved.
- Async reset mid-DATA: assert `reset_i` low after 4 bits → all outputs 0 immediately; the next complete frame 0x55 is received intact. Repeat all scenarios with `UART_RX_FIFO_EN` undefined (overrun occurs on the 2nd unread byte).
